// File: rtl/accel_stream_feeder.sv
// accel_stream_feeder: feeds memory words to a start/done accelerator; ACC_TIMEOUT_EN adds a watchdog, FE_DATA_W sets width
`ifndef FE_DATA_W
`define FE_DATA_W 32
`endif
module accel_stream_feeder #(
  parameter int DATA_W = `FE_DATA_W,
  parameter int ADDR_W = 16,
  parameter int LEN_W = 16,
  parameter int TMO_W = 8
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              go_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] result_o,
  output logic [LEN_W-1:0]  words_o,
  output logic              err_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              acc_start_o,
  output logic [DATA_W-1:0] acc_data_o,
  input  logic              acc_done_i,
  input  logic [DATA_W-1:0] acc_result_i
);
  typedef enum logic [2:0] {IDLE, MEM_REQ, MEM_WAIT, ACC_REQ, ACC_REL, FINISH} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0] len_q, len_d, words_q, words_d;
  logic [DATA_W-1:0] data_q, data_d, result_q, result_d;
  logic err_q, err_d;
  logic [TMO_W-1:0] tmo_q;
  logic tmo_hit;
`ifdef ACC_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge arst_n_i)
    if (!arst_n_i) tmo_q <= '0;
    else tmo_q <= (state_d != state_q || !(state_q inside {ACC_REQ, ACC_REL})) ? '0 : tmo_q + 1'b1;
`else
  assign tmo_q = '0;
`endif
  assign tmo_hit = &tmo_q;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    len_d = len_q;
    words_d = words_q;
    data_d = data_q;
    result_d = result_q;
    err_d = err_q;
    unique case (state_q)
      IDLE: if (go_i) begin
        addr_d = base_addr_i;
        len_d = len_i;
        words_d = '0;
        err_d = 1'b0;
        state_d = (len_i == '0) ? FINISH : MEM_REQ;
      end
      MEM_REQ: state_d = MEM_WAIT;
      MEM_WAIT: if (mem_rvalid_i) begin
        data_d = mem_rdata_i;
        state_d = ACC_REQ;
      end
      ACC_REQ: if (acc_done_i) begin
        result_d = acc_result_i;
        words_d = words_q + 1'b1;
        addr_d = addr_q + 1'b1;
        state_d = ACC_REL;
      end else if (tmo_hit) begin
        err_d = 1'b1;
        state_d = FINISH;
      end
      // waiting for done to fall keeps a lingering done from counting twice
      ACC_REL: if (!acc_done_i) state_d = (words_q == len_q) ? FINISH : MEM_REQ;
      else if (tmo_hit) begin
        err_d = 1'b1;
        state_d = FINISH;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge arst_n_i)
    if (!arst_n_i) begin
      state_q <= IDLE;
      addr_q <= '0;
      len_q <= '0;
      words_q <= '0;
      data_q <= '0;
      result_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      len_q <= len_d;
      words_q <= words_d;
      data_q <= data_d;
      result_q <= result_d;
      err_q <= err_d;
    end
  assign busy_o = !(state_q == IDLE || state_q == FINISH);
  assign done_o = state_q == FINISH;
  assign mem_req_o = state_q == MEM_REQ;
  assign mem_addr_o = addr_q;
  assign acc_start_o = state_q == ACC_REQ && !tmo_hit;
  assign acc_data_o = data_q;
  assign result_o = result_q;
  assign words_o = words_q;
  assign err_o = err_q;
endmodule

// File: tb/tb_accel_stream_feeder.sv
// tb_accel_stream_feeder: directed runs against a protocol-level model plus hand-computed run results
module tb_accel_stream_feeder;
  logic clk = 0, rst_n = 0, go = 0;
  logic [15:0] base = 0, len = 0;
  logic busy, done, err, mem_req, mem_rvalid, acc_start, acc_done;
  logic [15:0] words, mem_addr, pend_a, exp_a;
  logic [31:0] result, mem_rdata, acc_data, acc_cnt;
  int checks = 0, errors = 0, cyc = 0, lat = 1, hold_cfg = 0, hold, pend_c, l, c0;
  bit stuck = 0, mdl_on = 1, prev_start = 0, old_act, nd, nreq, nstart;
  bit m_act, m_done, m_req, m_wait, m_start, m_rel;
  int m_words, m_len;
  logic [15:0] m_base;
  logic [31:0] m_res, m_data;
  logic [31:0] mem [int];
  logic [15:0] q_addr [$];
  logic [31:0] q_data [$];

  accel_stream_feeder #(.TMO_W(4)) dut (
    .clk_i(clk), .arst_n_i(rst_n), .go_i(go), .base_addr_i(base), .len_i(len),
    .busy_o(busy), .done_o(done), .result_o(result), .words_o(words), .err_o(err),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .acc_start_o(acc_start), .acc_data_o(acc_data), .acc_done_i(acc_done), .acc_result_i(acc_cnt)
  );

  always #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end
  initial begin #200000; $display("FAIL watchdog: simulation did not finish, got hang expected finish"); $fatal(1); end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int evens(input logic [31:0] w);
    int n = 0;
    for (int i = 0; i < 4; i++) n += (w[8*i] == 1'b0) ? 1 : 0;
    return n;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [15:0] a);
    return mem.exists(int'(a)) ? mem[int'(a)] : 32'hDEAD_BEEF;
  endfunction

  // memory with configurable read latency
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_rvalid <= 0; mem_rdata <= 0; pend_c <= 0; pend_a <= 0;
    end else begin
      mem_rvalid <= 0;
      if (mem_req) begin
        pend_a <= mem_addr; pend_c <= lat - 1;
        if (lat == 1) begin mem_rvalid <= 1; mem_rdata <= mem_rd(mem_addr); end
      end else if (pend_c > 0) begin
        pend_c <= pend_c - 1;
        if (pend_c == 1) begin mem_rvalid <= 1; mem_rdata <= mem_rd(pend_a); end
      end
    end

  // even-byte counting accelerator, 4-phase responder
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc_done <= 0; acc_cnt <= 0; hold <= 0;
    end else if (acc_start && !acc_done && !stuck) begin
      acc_cnt <= acc_cnt + 32'(evens(acc_data)); acc_done <= 1; hold <= hold_cfg;
    end else if (!acc_start && acc_done) begin
      if (hold == 0) acc_done <= 0; else hold <= hold - 1;
    end

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_ctl", {busy, done, mem_req, acc_start, err}, 0);
      chk("rst_data", {words, mem_addr, result}, 0);
      chk("rst_acc_data", acc_data, 0);
      {m_act, m_done, m_req, m_wait, m_start, m_rel} = '0;
      m_words = 0; m_len = 0; m_base = 0; m_res = 0; m_data = 0;
    end else if (mdl_on) begin
      exp_a = m_base + 16'(m_words);
      chk("done", done, m_done);
      chk("busy", busy, m_act && !m_done);
      chk("mem_req", mem_req, m_req);
      if (m_req) chk("mem_addr", mem_addr, exp_a);
      chk("acc_start", acc_start, m_start);
      if (m_start) chk("acc_data", acc_data, m_data);
      chk("words", words, m_words);
      chk("result", result, m_res);
      chk("err", err, 0);
      if (mem_req) q_addr.push_back(mem_addr);
      if (acc_start && !prev_start) q_data.push_back(acc_data);
      prev_start = acc_start;
      old_act = m_act; nd = 0; nreq = 0; nstart = m_start;
      if (m_done) m_act = 0;
      if (m_req) m_wait = 1;
      else if (m_wait && mem_rvalid) begin m_wait = 0; nstart = 1; m_data = mem_rdata; end
      if (m_start && acc_done) begin
        m_words++; m_res = acc_cnt; m_rel = 1; nstart = 0;
      end else if (m_rel && !acc_done) begin
        m_rel = 0;
        if (m_words == m_len) nd = 1; else nreq = 1;
      end
      if (go && !old_act) begin
        m_act = 1; m_base = base; m_len = int'(len); m_words = 0; m_rel = 0;
        if (len == 0) nd = 1; else nreq = 1;
      end
      m_req = nreq; m_start = nstart; m_done = nd;
    end
  end

  task automatic run(input logic [15:0] b, input logic [15:0] n, input bit spam, output int latency);
    int s;
    bit seen = 0;
    q_addr.delete(); q_data.delete();
    @(posedge clk); #1 base = b; len = n; go = 1; s = cyc;
    @(posedge clk); #1 go = 0;
    latency = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; latency = cyc - s + 1; end
      else begin @(posedge clk); #1 go = spam && !go; end
    end
    go = 0;
    chk("done_seen", seen, 1);
  endtask

  initial begin
    mem[16'h0010] = 32'h04030201; mem[16'h0011] = 32'h0A0B0C0D;
    mem[16'h0020] = 32'h02040601;
    mem[16'hFFFF] = 32'h11111111; mem[16'h0000] = 32'h11111110;
    mem[16'h0030] = 32'h00000000; mem[16'h0031] = 32'h01010101; mem[16'h0032] = 32'h22222223;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    stuck = 1;
    @(posedge clk); #1 base = 16'h0040; len = 1; go = 1;
    @(posedge clk); #1 go = 0;
    repeat (2) @(posedge clk);
    #3 chk("pre_rst_start", acc_start, 1);
    rst_n = 0;
    #1 chk("async_rst", {acc_start, busy, mem_req, done}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1; stuck = 0;
    run(16'h0010, 2, 0, l);
    chk("t2_latency", l, 14);
    chk("t2_result", result, 4);
    chk("t2_words", words, 2);
    chk("t2_nstarts", q_data.size(), 2);
    if (q_data.size() == 2) begin
      chk("t2_word0", q_data[0], 32'h04030201);
      chk("t2_word1", q_data[1], 32'h0A0B0C0D);
    end
    run(16'h0020, 1, 0, l);
    chk("t3_latency", l, 8);
    chk("t3_result", result, 7);
    q_addr.delete(); q_data.delete();
    @(posedge clk); #1 base = 16'h0050; len = 0; go = 1; c0 = cyc;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_done", done, 1);
    chk("t4_latency", cyc - c0 + 1, 2);
    chk("t4_result", result, 7);
    chk("t4_words", words, 0);
    @(posedge clk); #1 go = 0;
    @(negedge clk);
    chk("t4_go_in_finish_ignored", {busy, done}, 0);
    chk("t4_traffic", q_addr.size() + q_data.size(), 0);
    lat = 3;
    run(16'hFFFF, 2, 0, l);
    chk("t5_latency", l, 18);
    chk("t5_result", result, 8);
    chk("t5_nreq", q_addr.size(), 2);
    if (q_addr.size() == 2) begin
      chk("t5_addr0", q_addr[0], 16'hFFFF);
      chk("t5_addr1", q_addr[1], 16'h0000);
    end
    lat = 1; hold_cfg = 4;
    run(16'h0030, 3, 1, l);
    chk("t6_latency", l, 32);
    chk("t6_words", words, 3);
    chk("t6_result", result, 15);
    hold_cfg = 0;
`ifdef ACC_TIMEOUT_EN
    repeat (8) @(posedge clk);
    mdl_on = 0; stuck = 1;
    run(16'h0060, 1, 1, l);
    chk("tmo_latency", l, 20);
    chk("tmo_err", err, 1);
    chk("tmo_start", acc_start, 0);
    chk("tmo_result", result, 15);
    @(negedge clk);
    chk("tmo_err_hold", {err, busy}, 2'b10);
`endif
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
